// File: rtl/subblock_byte_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : subblock_byte_serializer_pkg
//  Description : Shared constants for the subblock byte serializer: subblock
//                sizes (also used by the encoder's length logic) and the
//                serializer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package subblock_byte_serializer_pkg;

    // Bytes per subblock for a short (1056-bit) and a long (6144-bit) block.
    localparam int SUBBLK_BYTES_SHORT = 132;
    localparam int SUBBLK_BYTES_LONG  = 768;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_req   = 3'd1;
    localparam state_t c_st_wait  = 3'd2;
    localparam state_t c_st_emit0 = 3'd3;
    localparam state_t c_st_emit1 = 3'd4;
    localparam state_t c_st_emit2 = 3'd5;

endpackage
`default_nettype wire

// File: rtl/subblock_byte_serializer_done_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : done_edge_detect
//  Description : Registers computation_done and produces a one-cycle start
//                pulse on its rising edge.
//  Ports       : clk              in   clock, rising edge
//                reset            in   asynchronous active-low reset
//                computation_done in   level from the encoder
//                start            out  high while done=1 and last sample=0
//  Revision    : 1.0  initial release
// ============================================================================
module done_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic computation_done,
    output logic start
);

    logic r_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= computation_done;
        end
    end

    assign start = computation_done & ~r_done_q;

endmodule
`default_nettype wire

// File: rtl/subblock_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : subblock_byte_serializer
//  Description : Drains the encoder's three subblock FIFOs after
//                computation_done and emits one byte stream d0,d1,d2 per
//                read over a valid/ready handshake, with start/end-of-block
//                markers for the rate-matching stage.
//  Ports       : clk, reset(async, active-low)
//                computation_done, code_block_length   block start/length
//                q0..q2 / rdreq_subblock               subblock FIFO read side
//                out_data/out_valid/out_ready          byte stream
//                out_sob/out_eob                       framing, valid-qualified
//                busy                                  block in progress
//  Revision    : 1.0  initial release
// ============================================================================
module subblock_byte_serializer
    import subblock_byte_serializer_pkg::*;
#(
    parameter int BYTES_SHORT = SUBBLK_BYTES_SHORT,
    parameter int BYTES_LONG  = SUBBLK_BYTES_LONG,
    parameter int CNT_W       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       computation_done,
    input  logic       code_block_length,
    input  logic [7:0] q0,
    input  logic [7:0] q1,
    input  logic [7:0] q2,
    output logic       rdreq_subblock,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sob,
    output logic       out_eob,
    output logic       busy
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_len;
    logic [7:0]         r_h0;
    logic [7:0]         r_h1;
    logic [7:0]         r_h2;

    logic               w_start;
    logic               w_emitting;
    logic               w_accept;
    logic [CNT_W-1:0]   w_limit;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_last_triple;
    logic               w_final_byte;

    done_edge_detect u_done_edge (
        .clk              (clk),
        .reset            (reset),
        .computation_done (computation_done),
        .start            (w_start)
    );

    // Limit comes from the length latched at start, so a mid-block change
    // of code_block_length cannot alter the triple count.
    assign w_limit       = r_len ? CNT_W'(BYTES_LONG) : CNT_W'(BYTES_SHORT);
    assign w_cnt_inc     = r_cnt + CNT_W'(1);
    assign w_last_triple = (w_cnt_inc == w_limit);

    assign w_emitting    = (r_state == c_st_emit0) || (r_state == c_st_emit1) ||
                           (r_state == c_st_emit2);
    assign w_accept      = w_emitting && out_ready;
    assign w_final_byte  = (r_state == c_st_emit2) && w_last_triple;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (w_start) w_state_next = c_st_req;
            c_st_req:   w_state_next = c_st_wait;
            c_st_wait:  w_state_next = c_st_emit0;
            c_st_emit0: if (w_accept) w_state_next = c_st_emit1;
            c_st_emit1: if (w_accept) w_state_next = c_st_emit2;
            c_st_emit2: begin
                if (w_accept) begin
                    w_state_next = w_last_triple ? c_st_idle : c_st_req;
                end
            end
            default:    w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (Moore: every output is a function of state and held data,
    // so they stay stable across a stall)
    // ------------------------------------------------------------------
    always_comb begin
        rdreq_subblock = 1'b0;
        out_data       = 8'h00;
        out_valid      = 1'b0;
        out_sob        = 1'b0;
        out_eob        = 1'b0;
        busy           = (r_state != c_st_idle);
        case (r_state)
            c_st_req:   rdreq_subblock = 1'b1;
            c_st_emit0: begin
                out_data  = r_h0;
                out_valid = 1'b1;
                out_sob   = (r_cnt == '0);
            end
            c_st_emit1: begin
                out_data  = r_h1;
                out_valid = 1'b1;
            end
            c_st_emit2: begin
                out_data  = r_h2;
                out_valid = 1'b1;
                out_eob   = w_final_byte;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: length latch, holding registers, triple counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len <= 1'b0;
            r_h0  <= 8'h00;
            r_h1  <= 8'h00;
            r_h2  <= 8'h00;
            r_cnt <= '0;
        end else begin
            if ((r_state == c_st_idle) && w_start) begin
                r_len <= code_block_length;
            end
            // FIFO read latency is one cycle: data is valid during WAIT.
            if (r_state == c_st_wait) begin
                r_h0 <= q0;
                r_h1 <= q1;
                r_h2 <= q2;
            end
            if ((r_state == c_st_emit2) && w_accept) begin
                r_cnt <= w_last_triple ? '0 : w_cnt_inc;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/subblock_byte_serializer.md
Name: subblock_byte_serializer

Overview:
- Downstream consumer of the parallel convolutional encoder's three subblock output FIFOs (d0/d1/d2 bytes on q0/q1/q2, popped together by a single rdreq_subblock).
- After the encoder signals computation_done, drains all three subblocks and emits one byte stream in triple order d0,d1,d2 per read, under a valid/ready handshake.
- Marks start and end of each code block so the next stage (rate matching) can frame it.

Parameters:
- BYTES_SHORT, 132, bytes per subblock when code_block_length=0 (1056 bits)
- BYTES_LONG, 768, bytes per subblock when code_block_length=1 (6144 bits)
- CNT_W, 10, width of the triple counter; must hold BYTES_LONG

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- computation_done  in  1  encoder finished the block; subblock FIFOs are full
- code_block_length  in  1  0 = short block, 1 = long block; sampled at start
- q0  in  8  subblock d0 FIFO read data
- q1  in  8  subblock d1 FIFO read data
- q2  in  8  subblock d2 FIFO read data
- rdreq_subblock  out  1  one-cycle pop of all three subblock FIFOs
- out_data  out  8  serialized byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_sob  out  1  first byte of block (d0 of triple 0), qualified by out_valid
- out_eob  out  1  last byte of block (d2 of final triple), qualified by out_valid
- busy  out  1  high from start until the last byte is accepted

Behaviour:
- Reset (reset=0, async): state=IDLE; rdreq_subblock, out_valid, out_sob, out_eob, busy = 0; out_data = 8'h00; counter = 0; holding regs = 0; done edge register = 0.
- Start: rising edge of computation_done, detected with a registered copy, while in IDLE. Latch code_block_length into len_r. limit = len_r ? BYTES_LONG : BYTES_SHORT. busy=1 the next cycle.
- A rising edge outside IDLE is ignored. No queueing.
- States and transitions:
  - IDLE: on start, go to REQ.
  - REQ: assert rdreq_subblock for exactly one cycle, then go to WAIT.
  - WAIT: FIFO read latency is 1 cycle; q0..q2 are valid in this cycle. Capture them into h0..h2, then go to EMIT0.
  - EMIT0: out_data=h0, out_valid=1. On accept, go to EMIT1.
  - EMIT1: out_data=h1. On accept, go to EMIT2.
  - EMIT2: out_data=h2. On accept, counter++. If counter+1 == limit, go to IDLE, clear counter, and drop busy. Otherwise go to REQ.
- Handshake rules:
  - out_valid stays high and out_data, out_sob, out_eob stay stable until accepted. Never retracted.
  - out_ready may toggle freely; a stall holds the state indefinitely.
  - rdreq_subblock is never asserted while out_valid=1 or in WAIT. At most one outstanding read.
- Framing flags:
  - out_sob=1 only in EMIT0 with counter==0.
  - out_eob=1 only in EMIT2 with counter==limit-1.
- Throughput: 3 bytes per 5 cycles with out_ready tied high. A short block takes 660 cycles from REQ to the last accept.
- Counter arithmetic: CNT_W unsigned, compared with ==, no wrap. The limit is frozen for the whole block, even if code_block_length changes mid-block.
- computation_done held high across a whole block: no restart. A new block needs a low-then-high transition after returning to IDLE.
- Reset mid-operation: everything clears immediately, with no partial flags. Flushing the encoder FIFOs is the encoder's responsibility.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, REQ, WAIT, EMIT0, EMIT1, EMIT2);
  - BYTES_SHORT and BYTES_LONG constants, shared with the encoder's length logic.
- One natural sub-module: done_edge_detect. It registers computation_done and outputs a start pulse, and uses the same async active-low reset.
- The FSM, counter and holding regs stay in the top module.

Test Plan:
- Short block, out_ready=1, q0/q1/q2 = 8'h10+i, 8'h20+i, 8'h30+i (mod 256) -> 396 bytes in order 10,20,30,11,21,31,…; out_sob on byte 0; out_eob on byte 395; exactly 132 rdreq pulses; busy falls after byte 395.
- Long block (code_block_length=1) -> 2304 bytes, 768 rdreq pulses. Toggle code_block_length mid-block -> count unchanged.
- Random out_ready (≈50%) -> out_data stable while stalled; no byte lost or duplicated; rdreq never overlaps out_valid.
- computation_done held high after completion -> no second block. Drop it low, then raise it -> second block starts, out_sob again.
- Assert reset=0 asynchronously mid-EMIT1 (between clock edges) -> all outputs 0 immediately. After release, the next start produces a clean full block.
- Rising edge of computation_done while busy -> ignored; byte count still 396 for a short block.
